trace_capture_buffer: RTL and testbench

Parametrised multi-channel trace capture buffer with a single clock domain. It samples CHANNELS trace lanes into a circular on-chip memory and supports two modes: trace mode (pre/post-trigger window) and stream mode (triggered FIFO). A ready/valid control port configures and arms each run; a ready/valid data port delivers samples. It is the successor of the current fixed-width logger peripheral and sits behind the same system-side handshake interfaces.

---
 rtl/trace_capture_buffer_if.sv | 65 ++++++
 rtl/trace_capture_buffer.sv | 261 ++++++++++++++++++++++++++
 tb/tb_trace_capture_buffer.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trace_capture_buffer_if.sv
// ----------------------------------------------------------------------------
// trace_capture_buffer_if
//
// Bundles the control, trace-sample and readout handshakes of the trace
// capture buffer so the buffer and its system-side driver share one port.
//
// Signals (direction seen from the buffer, i.e. the slave modport):
//   CTRL_VALID_I / CTRL_READY_O  control word handshake
//   CTRL_MODE_I                  0 = trace mode, 1 = stream mode
//   CTRL_MASK_I                  per-lane trigger enable
//   CTRL_POST_I                  post-trigger sample count (trace mode)
//   TRACE_VALID_I / TRACE_I      sample strobe and packed lane data
//   TRIG_I                       per-lane trigger inputs
//   DATA_VALID_O / DATA_READY_I  readout handshake
//   DATA_O                       readout sample (timestamp in the MSBs when
//                                TCB_TIMESTAMP_EN is defined)
//   STATE_O, TRIGGERED_O, FILL_O, OVERFLOW_O  status
//
// Build option: TCB_TIMESTAMP_EN widens DATA_O by a 16-bit timestamp.
// ----------------------------------------------------------------------------
interface trace_capture_buffer_if #(
    parameter int TRACE_WIDTH = 8,
    parameter int CHANNELS    = 4,
    parameter int DEPTH       = 256
);
    localparam int ADDR_W   = $clog2(DEPTH);
    localparam int SAMPLE_W = CHANNELS * TRACE_WIDTH;
`ifdef TCB_TIMESTAMP_EN
    localparam int DATA_W   = SAMPLE_W + 16;
`else
    localparam int DATA_W   = SAMPLE_W;
`endif

    logic                  CTRL_VALID_I;
    logic                  CTRL_READY_O;
    logic                  CTRL_MODE_I;
    logic [CHANNELS-1:0]   CTRL_MASK_I;
    logic [ADDR_W-1:0]     CTRL_POST_I;
    logic                  TRACE_VALID_I;
    logic [SAMPLE_W-1:0]   TRACE_I;
    logic [CHANNELS-1:0]   TRIG_I;
    logic                  DATA_VALID_O;
    logic                  DATA_READY_I;
    logic [DATA_W-1:0]     DATA_O;
    logic [1:0]            STATE_O;
    logic                  TRIGGERED_O;
    logic [ADDR_W:0]       FILL_O;
    logic                  OVERFLOW_O;

    // The system side drives control, samples and readout ready.
    modport master (
        output CTRL_VALID_I, CTRL_MODE_I, CTRL_MASK_I, CTRL_POST_I,
               TRACE_VALID_I, TRACE_I, TRIG_I, DATA_READY_I,
        input  CTRL_READY_O, DATA_VALID_O, DATA_O, STATE_O,
               TRIGGERED_O, FILL_O, OVERFLOW_O
    );

    // The capture buffer consumes those and reports data and status.
    modport slave (
        input  CTRL_VALID_I, CTRL_MODE_I, CTRL_MASK_I, CTRL_POST_I,
               TRACE_VALID_I, TRACE_I, TRIG_I, DATA_READY_I,
        output CTRL_READY_O, DATA_VALID_O, DATA_O, STATE_O,
               TRIGGERED_O, FILL_O, OVERFLOW_O
    );
endinterface

// File: rtl/trace_capture_buffer.sv
// ----------------------------------------------------------------------------
// trace_capture_buffer
//
// Multi-channel trace capture buffer. CHANNELS lanes of TRACE_WIDTH bits are
// sampled into a DEPTH-entry circular memory. Two modes are supported:
//   trace mode  - records continuously while armed, keeps the newest DEPTH
//                 samples, stops CTRL_POST samples after the trigger and then
//                 offers the window for readout, oldest first.
//   stream mode - waits for a trigger, then behaves as a FIFO from the trace
//                 port to the readout port, dropping samples when full.
//
// Ports:
//   CLK_I   clock
//   RST_I   synchronous active-high reset
//   bus     trace_capture_buffer_if.slave (control, samples, readout, status)
//
// Build option: define TCB_TIMESTAMP_EN to store a 16-bit cycle counter
// alongside every sample; it appears in the MSBs of DATA_O.
// ----------------------------------------------------------------------------
module trace_capture_buffer #(
    parameter int TRACE_WIDTH = 8,
    parameter int CHANNELS    = 4,
    parameter int DEPTH       = 256
) (
    input logic                    CLK_I,
    input logic                    RST_I,
    trace_capture_buffer_if.slave  bus
);
    localparam int ADDR_W   = $clog2(DEPTH);
    localparam int FILL_W   = ADDR_W + 1;
    localparam int SAMPLE_W = CHANNELS * TRACE_WIDTH;
`ifdef TCB_TIMESTAMP_EN
    localparam int TS_W     = 16;
    localparam int DATA_W   = SAMPLE_W + TS_W;
`else
    localparam int DATA_W   = SAMPLE_W;
`endif
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t               state_q;
    state_t               state_d;

    logic                 mode_q;
    logic [CHANNELS-1:0]  mask_q;
    logic [ADDR_W-1:0]    post_q;
    logic [ADDR_W-1:0]    post_cnt_q;
    logic [ADDR_W-1:0]    wr_ptr_q;
    logic [ADDR_W-1:0]    rd_ptr;
    logic [FILL_W-1:0]    fill_q;
    logic                 triggered_q;
    logic                 overflow_q;

    logic [DATA_W-1:0]    mem [DEPTH];
    logic [DATA_W-1:0]    wr_data;

    logic                 trig_hit;
    logic                 ctrl_ready;
    logic                 ctrl_accept;
    logic                 data_valid;
    logic                 wr_en;
    logic                 rd_en;
    logic                 drop;
    logic                 set_trig;
    logic                 load_post;
    logic                 dec_post;

    // Any enabled lane firing counts as the trigger; whether it is acted on
    // is decided by the FSM, which only looks at it while armed.
    assign trig_hit = |(bus.TRIG_I & mask_q);

    // The read pointer is never stored: the unread entries always sit
    // directly behind the write pointer, so the oldest one is wr_ptr - fill.
    // This covers trace-mode wraparound (fill saturated, rd == wr) and FIFO
    // operation alike, and keeps DATA_O steady while a stalled FIFO keeps
    // accepting writes because both terms then advance together.
    assign rd_ptr = wr_ptr_q - fill_q[ADDR_W-1:0];

    // State register.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath strobes. Every strobe starts inactive and the
    // state decides which ones fire. A control accept overrides everything
    // else: it restarts the run, so nothing from the current cycle may land
    // in the buffer or the status flags.
    always_comb begin
        state_d    = state_q;
        ctrl_ready = 1'b0;
        data_valid = 1'b0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        drop       = 1'b0;
        set_trig   = 1'b0;
        load_post  = 1'b0;
        dec_post   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ctrl_ready = 1'b1;
            end

            ST_ARMED: begin
                if (!mode_q) begin
                    wr_en = bus.TRACE_VALID_I;
                    if (trig_hit) begin
                        set_trig  = 1'b1;
                        load_post = 1'b1;
                        state_d   = (post_q == '0) ? ST_DONE : ST_RUN;
                    end
                end else if (trig_hit) begin
                    set_trig = 1'b1;
                    wr_en    = bus.TRACE_VALID_I;
                    state_d  = ST_RUN;
                end
            end

            ST_RUN: begin
                if (mode_q) begin
                    ctrl_ready = 1'b1;
                    data_valid = (fill_q != '0);
                    rd_en      = data_valid & bus.DATA_READY_I;
                    if (bus.TRACE_VALID_I) begin
                        if ((fill_q != FILL_FULL) || rd_en) begin
                            wr_en = 1'b1;
                        end else begin
                            drop = 1'b1;
                        end
                    end
                end else if (bus.TRACE_VALID_I) begin
                    wr_en    = 1'b1;
                    dec_post = 1'b1;
                    if (post_cnt_q == ADDR_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                ctrl_ready = 1'b1;
                if (!mode_q) begin
                    data_valid = (fill_q != '0);
                    rd_en      = data_valid & bus.DATA_READY_I;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ctrl_accept = ctrl_ready & bus.CTRL_VALID_I;
        if (ctrl_accept) begin
            state_d   = ST_ARMED;
            wr_en     = 1'b0;
            rd_en     = 1'b0;
            drop      = 1'b0;
            set_trig  = 1'b0;
            load_post = 1'b0;
            dec_post  = 1'b0;
        end
    end

    // Run configuration, pointers, fill level and sticky flags. The fill
    // count saturates at DEPTH in trace mode, where the oldest entry is
    // simply overwritten; in stream mode the FSM never writes into a full
    // buffer unless a read frees a slot in the same cycle, so the same
    // update rule serves both modes.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            mode_q      <= 1'b0;
            mask_q      <= '0;
            post_q      <= '0;
            post_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            triggered_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else if (ctrl_accept) begin
            mode_q      <= bus.CTRL_MODE_I;
            mask_q      <= bus.CTRL_MASK_I;
            post_q      <= bus.CTRL_POST_I;
            post_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            triggered_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            end

            if (wr_en && !rd_en && (fill_q != FILL_FULL)) begin
                fill_q <= fill_q + FILL_W'(1);
            end else if (rd_en && !wr_en) begin
                fill_q <= fill_q - FILL_W'(1);
            end

            if (set_trig) begin
                triggered_q <= 1'b1;
            end

            if (drop) begin
                overflow_q <= 1'b1;
            end

            if (load_post) begin
                post_cnt_q <= post_q;
            end else if (dec_post) begin
                post_cnt_q <= post_cnt_q - ADDR_W'(1);
            end
        end
    end

`ifdef TCB_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;

    // Free-running cycle counter; restarting it on every control accept
    // makes stored timestamps relative to the start of the run.
    always_ff @(posedge CLK_I) begin
        if (RST_I || ctrl_accept) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
        end
    end

    assign wr_data = {ts_q, bus.TRACE_I};
`else
    assign wr_data = bus.TRACE_I;
`endif

    // Sample memory. It has no reset: after a reset the fill count is zero,
    // so stale contents are never presented.
    always_ff @(posedge CLK_I) begin
        if (wr_en && !RST_I) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    // Readout is an asynchronous read of the oldest unread entry.
    assign bus.DATA_O       = mem[rd_ptr];
    assign bus.DATA_VALID_O = data_valid;
    assign bus.CTRL_READY_O = ctrl_ready;
    assign bus.STATE_O      = state_q;
    assign bus.TRIGGERED_O  = triggered_q;
    assign bus.OVERFLOW_O   = overflow_q;
    assign bus.FILL_O       = fill_q;

endmodule

// File: tb/tb_trace_capture_buffer.sv
// ----------------------------------------------------------------------------
// tb_trace_capture_buffer
//
// Self-checking bench for trace_capture_buffer (DEPTH=8, CHANNELS=2,
// TRACE_WIDTH=4). A queue-based reference model follows the buffer's
// observable behaviour; a monitor compares status every cycle and pops the
// scoreboard whenever a readout handshake is presented. Directed scenarios
// are followed by a randomized phase.
// ----------------------------------------------------------------------------
module tb_trace_capture_buffer;
    localparam int TRACE_WIDTH = 4;
    localparam int CHANNELS    = 2;
    localparam int DEPTH       = 8;
    localparam int SAMPLE_W    = CHANNELS * TRACE_WIDTH;
`ifdef TCB_TIMESTAMP_EN
    localparam int DATA_W      = SAMPLE_W + 16;
`else
    localparam int DATA_W      = SAMPLE_W;
`endif
    localparam int ST_IDLE  = 0;
    localparam int ST_ARMED = 1;
    localparam int ST_RUN   = 2;
    localparam int ST_DONE  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   monOn = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    trace_capture_buffer_if #(
        .TRACE_WIDTH(TRACE_WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH)
    ) bus ();

    trace_capture_buffer #(
        .TRACE_WIDTH(TRACE_WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH)
    ) dut (
        .CLK_I(clk),
        .RST_I(rst),
        .bus  (bus)
    );

    // Reference model state.
    int                mSt;
    bit                mMode;
    logic [1:0]        mMask;
    int                mPost;
    int                mRemain;
    int                mFill;
    bit                mTrig;
    bit                mOvf;
    logic [15:0]       mTs;
    logic [DATA_W-1:0] hist[$];
    logic [DATA_W-1:0] expq[$];

    function automatic bit modelValid();
        return (((mSt == ST_DONE) && !mMode) || ((mSt == ST_RUN) && mMode)) && (mFill != 0);
    endfunction

    function automatic bit modelReady();
        return (mSt == ST_IDLE) || (mSt == ST_DONE) || ((mSt == ST_RUN) && mMode);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic recordTrace(input logic [DATA_W-1:0] entry);
        hist.push_back(entry);
        if (hist.size() > DEPTH) void'(hist.pop_front());
        mFill = hist.size();
    endtask

    // Reference model: trace mode keeps the newest DEPTH samples in a queue
    // and hands the whole window to the scoreboard when capture stops;
    // stream mode pushes each accepted sample straight to the scoreboard.
    always @(posedge clk) begin
        logic [DATA_W-1:0] entry;
        bit rd;
        bit acc;
        bit hit;
`ifdef TCB_TIMESTAMP_EN
        entry = {mTs, bus.TRACE_I};
`else
        entry = bus.TRACE_I;
`endif
        if (rst) begin
            mSt = ST_IDLE; mMode = 0; mMask = '0; mPost = 0; mRemain = 0;
            mFill = 0; mTrig = 0; mOvf = 0; mTs = '0;
            hist.delete(); expq.delete();
        end else begin
            rd  = modelValid() && bus.DATA_READY_I;
            acc = modelReady() && bus.CTRL_VALID_I;
            hit = |(bus.TRIG_I & mMask);
            if (acc) begin
                mMode = bus.CTRL_MODE_I; mMask = bus.CTRL_MASK_I; mPost = int'(bus.CTRL_POST_I);
                mFill = 0; mTrig = 0; mOvf = 0; mSt = ST_ARMED; mTs = '0;
                hist.delete(); expq.delete();
            end else begin
                case (mSt)
                    ST_ARMED: begin
                        if (!mMode) begin
                            if (bus.TRACE_VALID_I) recordTrace(entry);
                            if (hit) begin
                                mTrig = 1;
                                if (mPost == 0) begin
                                    mSt = ST_DONE; expq = hist;
                                end else begin
                                    mRemain = mPost; mSt = ST_RUN;
                                end
                            end
                        end else if (hit) begin
                            mTrig = 1; mSt = ST_RUN;
                            if (bus.TRACE_VALID_I) begin
                                expq.push_back(entry); mFill = 1;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (!mMode) begin
                            if (bus.TRACE_VALID_I) begin
                                recordTrace(entry);
                                mRemain--;
                                if (mRemain == 0) begin
                                    mSt = ST_DONE; expq = hist;
                                end
                            end
                        end else begin
                            if (bus.TRACE_VALID_I) begin
                                if ((mFill < DEPTH) || rd) begin
                                    expq.push_back(entry); mFill++;
                                end else begin
                                    mOvf = 1;
                                end
                            end
                            if (rd) mFill--;
                        end
                    end
                    ST_DONE: begin
                        if (rd) mFill--;
                    end
                    default: ;
                endcase
                mTs = mTs + 16'd1;
            end
        end
    end

    // Monitor: status against the model every cycle; readout data against
    // the scoreboard whenever the DUT presents a handshake.
    always @(negedge clk) begin
        logic [DATA_W-1:0] e;
        if (monOn && !rst) begin
            checkOutput("state",      64'(bus.STATE_O),      64'(mSt));
            checkOutput("fill",       64'(bus.FILL_O),       64'(mFill));
            checkOutput("triggered",  64'(bus.TRIGGERED_O),  64'(mTrig));
            checkOutput("overflow",   64'(bus.OVERFLOW_O),   64'(mOvf));
            checkOutput("data_valid", 64'(bus.DATA_VALID_O), 64'(modelValid()));
            checkOutput("ctrl_ready", 64'(bus.CTRL_READY_O), 64'(modelReady()));
            if (bus.DATA_VALID_O && bus.DATA_READY_I) begin
                if (expq.size() == 0) begin
                    checkOutput("data_unexpected", 64'(bus.DATA_VALID_O), 64'(0));
                end else begin
                    e = expq.pop_front();
                    checkOutput("data", 64'(bus.DATA_O), 64'(e));
                end
            end
        end
    end

    task automatic applyStimulus(input bit cv, input bit mode, input logic [1:0] mask,
                                 input logic [2:0] post, input bit tv, input logic [7:0] data,
                                 input logic [1:0] trig, input bit ready);
        @(posedge clk);
        #1;
        bus.CTRL_VALID_I  = cv;
        bus.CTRL_MODE_I   = mode;
        bus.CTRL_MASK_I   = mask;
        bus.CTRL_POST_I   = post;
        bus.TRACE_VALID_I = tv;
        bus.TRACE_I       = data;
        bus.TRIG_I        = trig;
        bus.DATA_READY_I  = ready;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 2'b00, 3'd0, 0, 8'd0, 2'b00, 0);
    endtask

    task automatic sendCtrl(input bit mode, input logic [1:0] mask, input logic [2:0] post);
        applyStimulus(1, mode, mask, post, 0, 8'd0, 2'b00, 0);
        idle();
    endtask

    task automatic resetDut();
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drainExpect(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(0, 0, 2'b00, 3'd0, 0, 8'd0, 2'b00, 1);
            checkOutput("drain_valid", 64'(bus.DATA_VALID_O), 64'(1));
            checkOutput("drain_data",  64'(bus.DATA_O[SAMPLE_W-1:0]), 64'(first + i));
        end
        idle();
    endtask

    initial begin
        bus.CTRL_VALID_I = 0; bus.CTRL_MODE_I = 0; bus.CTRL_MASK_I = '0; bus.CTRL_POST_I = '0;
        bus.TRACE_VALID_I = 0; bus.TRACE_I = '0; bus.TRIG_I = '0; bus.DATA_READY_I = 0;

        // Reset held for two cycles.
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        monOn = 1'b1;
        checkOutput("rst_state",     64'(bus.STATE_O),      64'(0));
        checkOutput("rst_fill",      64'(bus.FILL_O),       64'(0));
        checkOutput("rst_valid",     64'(bus.DATA_VALID_O), 64'(0));
        checkOutput("rst_ready",     64'(bus.CTRL_READY_O), 64'(1));
        checkOutput("rst_triggered", 64'(bus.TRIGGERED_O),  64'(0));
        checkOutput("rst_overflow",  64'(bus.OVERFLOW_O),   64'(0));

        // Trace window with wraparound: trigger on sample 10, three after.
        sendCtrl(0, 2'b11, 3'd3);
        for (int k = 1; k <= 20; k++)
            applyStimulus(0, 0, 2'b00, 3'd0, 1, 8'(k), (k == 10) ? 2'b01 : 2'b00, 0);
        idle();
        checkOutput("t2_state", 64'(bus.STATE_O),     64'(ST_DONE));
        checkOutput("t2_fill",  64'(bus.FILL_O),      64'(8));
        checkOutput("t2_trig",  64'(bus.TRIGGERED_O), 64'(1));
        drainExpect(6, 8);
        checkOutput("t2_fill_empty",  64'(bus.FILL_O),       64'(0));
        checkOutput("t2_valid_empty", 64'(bus.DATA_VALID_O), 64'(0));

        // Zero post-trigger count stops on the trigger sample.
        sendCtrl(0, 2'b11, 3'd0);
        for (int k = 1; k <= 3; k++)
            applyStimulus(0, 0, 2'b00, 3'd0, 1, 8'(k), (k == 3) ? 2'b10 : 2'b00, 0);
        idle();
        checkOutput("t3_state", 64'(bus.STATE_O), 64'(ST_DONE));
        checkOutput("t3_fill",  64'(bus.FILL_O),  64'(3));
        drainExpect(1, 3);

        // Masked-off lane never triggers.
        sendCtrl(0, 2'b01, 3'd5);
        repeat (20) applyStimulus(0, 0, 2'b00, 3'd0, 0, 8'd0, 2'b10, 0);
        idle();
        checkOutput("t4_state", 64'(bus.STATE_O),      64'(ST_ARMED));
        checkOutput("t4_trig",  64'(bus.TRIGGERED_O),  64'(0));
        checkOutput("t4_valid", 64'(bus.DATA_VALID_O), 64'(0));
        resetDut();
        checkOutput("t4_reset_state", 64'(bus.STATE_O), 64'(ST_IDLE));

        // Stream mode filling past capacity with no reader.
        sendCtrl(1, 2'b11, 3'd0);
        applyStimulus(0, 0, 2'b00, 3'd0, 0, 8'd0, 2'b01, 0);
        for (int k = 1; k <= 10; k++)
            applyStimulus(0, 0, 2'b00, 3'd0, 1, 8'(k), 2'b00, 0);
        idle();
        checkOutput("t5_fill",     64'(bus.FILL_O),     64'(8));
        checkOutput("t5_overflow", 64'(bus.OVERFLOW_O), 64'(1));
        drainExpect(1, 8);
        checkOutput("t5_fill_empty", 64'(bus.FILL_O), 64'(0));

        // Stream mode at full: read and write together keep fill at DEPTH.
        sendCtrl(1, 2'b11, 3'd0);
        applyStimulus(0, 0, 2'b00, 3'd0, 0, 8'd0, 2'b10, 0);
        for (int k = 1; k <= 8; k++)
            applyStimulus(0, 0, 2'b00, 3'd0, 1, 8'(k), 2'b00, 0);
        applyStimulus(0, 0, 2'b00, 3'd0, 1, 8'd9, 2'b00, 1);
        idle();
        checkOutput("t6_fill",     64'(bus.FILL_O),     64'(8));
        checkOutput("t6_overflow", 64'(bus.OVERFLOW_O), 64'(0));
        drainExpect(2, 8);

        // Randomized traffic in both modes, with occasional reconfiguration
        // and resets.
        resetDut();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 599) == 0) begin
                resetDut();
            end else begin
                applyStimulus($urandom_range(0, 99) < 4,
                              1'($urandom_range(0, 1)),
                              2'($urandom_range(1, 3)),
                              3'($urandom_range(0, 7)),
                              $urandom_range(0, 99) < 70,
                              8'($urandom_range(0, 255)),
                              {($urandom_range(0, 99) < 8) ? 1'b1 : 1'b0,
                               ($urandom_range(0, 99) < 8) ? 1'b1 : 1'b0},
                              $urandom_range(0, 99) < 50);
            end
        end
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
